// File: rtl/rtc_pkg.sv
// Shared definitions for the RTC operation scheduler: state encoding, bus layout
// and one-hot grant values.
package rtc_pkg;

  typedef enum logic [4:0] {
    ST_BOOT  = 5'b00001,
    ST_IDLE  = 5'b00010,
    ST_INIT  = 5'b00100,
    ST_READ  = 5'b01000,
    ST_WRITE = 5'b10000
  } state_t;

  localparam logic [3:0] RTC_BUS_IDLE = 4'b1111;

  localparam int A_D = 3;
  localparam int CS  = 2;
  localparam int RD  = 1;
  localparam int WR  = 0;

  localparam logic [2:0] GNT_NONE  = 3'b000;
  localparam logic [2:0] GNT_INIT  = 3'b001;
  localparam logic [2:0] GNT_READ  = 3'b010;
  localparam logic [2:0] GNT_WRITE = 3'b100;

endpackage

// File: rtl/rtc_op_scheduler_if.sv
// Handshake and bus bundle between the scheduler (master) and the request
// sources / operation FSMs (slave).
interface rtc_op_scheduler_if;

  logic       wr_req;
  logic       init_req;
  logic       init_done;
  logic       read_done;
  logic       write_done;
  logic [3:0] init_bus;
  logic [3:0] read_bus;
  logic [3:0] write_bus;
  logic       do_it_inic;
  logic       do_it_read;
  logic       do_it_write;
  logic [2:0] gnt;
  logic       a_d;
  logic       cs;
  logic       rd;
  logic       wr;
  logic       busy;
  logic       init_ok;
  logic       timeout_err;
  logic       read_overrun;

  modport master (
    input  wr_req, init_req, init_done, read_done, write_done,
    input  init_bus, read_bus, write_bus,
    output do_it_inic, do_it_read, do_it_write, gnt,
    output a_d, cs, rd, wr, busy, init_ok, timeout_err, read_overrun
  );

  modport slave (
    output wr_req, init_req, init_done, read_done, write_done,
    output init_bus, read_bus, write_bus,
    input  do_it_inic, do_it_read, do_it_write, gnt,
    input  a_d, cs, rd, wr, busy, init_ok, timeout_err, read_overrun
  );

endinterface

// File: rtl/rtc_period_timer.sv
// Free-running 0..READ_PERIOD-1 counter, advancing only while enabled; tick is
// high during the last count of each period.
module rtc_period_timer #(
  parameter int READ_PERIOD = 1000000,
  parameter int CNT_W       = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tick
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(READ_PERIOD - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + CNT_W'(1);
    end
  end

  assign tick = en && (cnt == LAST);

endmodule

// File: rtl/rtc_op_scheduler.sv
// Shares the RTC bus between the init, periodic-read and user-write FSMs:
// latches requests, issues start pulses, waits for done under a watchdog.
module rtc_op_scheduler
  import rtc_pkg::*;
#(
  parameter int READ_PERIOD = 1000000,
  parameter int CNT_W       = 20,
  parameter int TIMEOUT     = 4096,
  parameter int TO_W        = 13
) (
  input  logic               clk,
  input  logic               reset,
  rtc_op_scheduler_if.master rtc
);

  localparam logic [TO_W-1:0] WD_LAST = TO_W'(TIMEOUT - 1);

  state_t          state;
  logic            init_pend;
  logic            wr_pend;
  logic            read_pend;
  logic [TO_W-1:0] wd_cnt;
  logic            tick;
  logic            start_cycle;
  logic            granted_done;
  logic            wd_expired;
  logic            init_done_acc;
  logic            go_init;
  logic            go_write;
  logic            go_read;
  logic [3:0]      bus_mux;

  rtc_period_timer #(
    .READ_PERIOD (READ_PERIOD),
    .CNT_W       (CNT_W)
  ) u_period_timer (
    .clk   (clk),
    .reset (reset),
    .en    (rtc.init_ok),
    .tick  (tick)
  );

  // A done seen during the start-pulse cycle is a leftover level from the previous run.
  assign start_cycle   = rtc.do_it_inic | rtc.do_it_read | rtc.do_it_write;
  assign granted_done  = rtc.busy && !start_cycle &&
                         (|(rtc.gnt & {rtc.write_done, rtc.read_done, rtc.init_done}));
  assign wd_expired    = rtc.busy && (wd_cnt == WD_LAST);
  assign init_done_acc = granted_done && (state == ST_INIT);

  assign go_init  = (state == ST_BOOT) || ((state == ST_IDLE) && init_pend);
  assign go_write = (state == ST_IDLE) && !init_pend && rtc.init_ok && wr_pend;
  assign go_read  = (state == ST_IDLE) && !init_pend && rtc.init_ok && !wr_pend && read_pend;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= ST_BOOT;
      rtc.do_it_inic   <= 1'b0;
      rtc.do_it_read   <= 1'b0;
      rtc.do_it_write  <= 1'b0;
      rtc.gnt          <= GNT_NONE;
      rtc.busy         <= 1'b0;
      rtc.init_ok      <= 1'b0;
      rtc.timeout_err  <= 1'b0;
      rtc.read_overrun <= 1'b0;
      init_pend        <= 1'b0;
      wr_pend          <= 1'b0;
      read_pend        <= 1'b0;
      wd_cnt           <= '0;
    end else begin
      rtc.do_it_inic  <= 1'b0;
      rtc.do_it_read  <= 1'b0;
      rtc.do_it_write <= 1'b0;

      case (state)
        ST_BOOT, ST_IDLE: begin
          if (go_init) begin
            state          <= ST_INIT;
            rtc.do_it_inic <= 1'b1;
            rtc.gnt        <= GNT_INIT;
            rtc.busy       <= 1'b1;
          end else if (go_write) begin
            state           <= ST_WRITE;
            rtc.do_it_write <= 1'b1;
            rtc.gnt         <= GNT_WRITE;
            rtc.busy        <= 1'b1;
          end else if (go_read) begin
            state          <= ST_READ;
            rtc.do_it_read <= 1'b1;
            rtc.gnt        <= GNT_READ;
            rtc.busy       <= 1'b1;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_INIT, ST_READ, ST_WRITE: begin
          if (granted_done || wd_expired) begin
            state    <= ST_IDLE;
            rtc.gnt  <= GNT_NONE;
            rtc.busy <= 1'b0;
            if (!granted_done) rtc.timeout_err <= 1'b1;
            if (init_done_acc) rtc.init_ok     <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase

      // A timed-out init keeps init_pend set, so IDLE retries it.
      init_pend <= rtc.init_req || (state == ST_BOOT) || (init_pend && !init_done_acc);
      wr_pend   <= (go_write || rtc.do_it_write) ? 1'b0 : (wr_pend || rtc.wr_req);
      read_pend <= tick || (read_pend && !go_read);
      if (tick && read_pend && !go_read) rtc.read_overrun <= 1'b1;

      if (go_init || go_write || go_read) wd_cnt <= '0;
      else if (rtc.busy)                  wd_cnt <= wd_cnt + TO_W'(1);
    end
  end

  always_comb begin
    bus_mux = RTC_BUS_IDLE;
    case (rtc.gnt)
      GNT_INIT:  bus_mux = rtc.init_bus;
      GNT_READ:  bus_mux = rtc.read_bus;
      GNT_WRITE: bus_mux = rtc.write_bus;
      default:   bus_mux = RTC_BUS_IDLE;
    endcase
  end

  assign rtc.a_d = bus_mux[A_D];
  assign rtc.cs  = bus_mux[CS];
  assign rtc.rd  = bus_mux[RD];
  assign rtc.wr  = bus_mux[WR];

endmodule

// File: tb/tb_rtc_op_scheduler.sv
// Directed bench for rtc_op_scheduler with READ_PERIOD=50 and TIMEOUT=64;
// the bench plays the three operation FSMs and the request sources.
module tb_rtc_op_scheduler;

  localparam int READ_PERIOD = 50;
  localparam int CNT_W       = 6;
  localparam int TIMEOUT     = 64;
  localparam int TO_W        = 7;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   tick0 = -1;
  logic [3:0] bus_o;

  always #5 clk = ~clk;

  rtc_op_scheduler_if ifc ();

  rtc_op_scheduler #(
    .READ_PERIOD (READ_PERIOD),
    .CNT_W       (CNT_W),
    .TIMEOUT     (TIMEOUT),
    .TO_W        (TO_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .rtc   (ifc)
  );

  assign bus_o = {ifc.a_d, ifc.cs, ifc.rd, ifc.wr};

  // Period ticks fall every READ_PERIOD cycles from tick0 onward.
  function automatic bit is_tick(input int c);
    return (tick0 >= 0) && (c >= tick0) && (((c - tick0) % READ_PERIOD) == 0);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_start(input int which, input int budget, output bit found);
    found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if ((which == 0 && ifc.do_it_inic) || (which == 1 && ifc.do_it_read) ||
          (which == 2 && ifc.do_it_write)) begin
        found = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic wait_tick(input int budget, output bit found);
    found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (is_tick(cyc)) begin
        found = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic finish_read(input int lat);
    for (int k = 1; k < lat; k++) step();
    ifc.read_done = 1'b1;
    step();
    ifc.read_done = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) step();
    vectors++;
    if (ifc.gnt !== 3'b000) begin miscompares++; $display("FAIL rst_gnt: got %b want 000", ifc.gnt); end
    vectors++;
    if ({ifc.do_it_inic, ifc.do_it_read, ifc.do_it_write, ifc.busy} !== 4'b0000) begin
      miscompares++;
      $display("FAIL rst_ctrl: got %b want 0000", {ifc.do_it_inic, ifc.do_it_read, ifc.do_it_write, ifc.busy});
    end
    vectors++;
    if (bus_o !== 4'b1111) begin miscompares++; $display("FAIL rst_bus: got %b want 1111", bus_o); end
    vectors++;
    if ({ifc.init_ok, ifc.timeout_err, ifc.read_overrun} !== 3'b000) begin
      miscompares++;
      $display("FAIL rst_flags: got %b want 000", {ifc.init_ok, ifc.timeout_err, ifc.read_overrun});
    end
    #2 reset = 1'b1;
    vectors++;
    if ({ifc.do_it_inic, ifc.gnt} !== 4'b0000) begin
      miscompares++;
      $display("FAIL boot_cycle: got %b want 0000", {ifc.do_it_inic, ifc.gnt});
    end
    step();
    vectors++;
    if ({ifc.do_it_inic, ifc.gnt, ifc.busy} !== 5'b1_001_1) begin
      miscompares++;
      $display("FAIL init_start: got %b want 10011", {ifc.do_it_inic, ifc.gnt, ifc.busy});
    end
  endtask

  task automatic test_init();
    int s;
    s = cyc;
    ifc.init_bus  = 4'b0101;
    ifc.read_bus  = 4'b1010;
    ifc.write_bus = 4'b0011;
    step();
    vectors++;
    if ({ifc.do_it_inic, bus_o} !== 5'b0_0101) begin
      miscompares++;
      $display("FAIL init_pulse_bus: got %b want 00101", {ifc.do_it_inic, bus_o});
    end
    while (cyc < s + 20) step();
    vectors++;
    if (ifc.gnt !== 3'b001) begin miscompares++; $display("FAIL init_held: got %b want 001", ifc.gnt); end
    ifc.init_done = 1'b1;
    tick0 = cyc + READ_PERIOD;
    step();
    ifc.init_done = 1'b0;
    vectors++;
    if ({ifc.gnt, ifc.busy, ifc.init_ok, bus_o} !== 9'b000_0_1_1111) begin
      miscompares++;
      $display("FAIL init_end: got %b want 000011111", {ifc.gnt, ifc.busy, ifc.init_ok, bus_o});
    end
  endtask

  task automatic test_periodic_read();
    int prev;
    int e;
    int gcnt;
    bit found;
    prev = -1;
    for (int r = 0; r < 3; r++) begin
      wait_start(1, 120, found);
      e = cyc;
      vectors++;
      if (!found) begin miscompares++; $display("FAIL read_start_%0d: got none want pulse", r); end
      vectors++;
      if (r == 0 && e !== tick0 + 2) begin
        miscompares++; $display("FAIL read_first_cycle: got %0d want %0d", e, tick0 + 2);
      end else if (r > 0 && (e - prev) !== READ_PERIOD) begin
        miscompares++; $display("FAIL read_spacing_%0d: got %0d want %0d", r, e - prev, READ_PERIOD);
      end
      ifc.read_bus = 4'(r + 4);
      #1;
      vectors++;
      if (bus_o !== 4'(r + 4)) begin miscompares++; $display("FAIL read_bus_%0d: got %b want %b", r, bus_o, 4'(r + 4)); end
      gcnt = 0;
      for (int k = 0; k < 10; k++) begin
        if (ifc.gnt === 3'b010) gcnt++;
        step();
      end
      if (ifc.gnt === 3'b010) gcnt++;
      ifc.read_done = 1'b1;
      step();
      ifc.read_done = 1'b0;
      if (ifc.gnt === 3'b010) gcnt++;
      vectors++;
      if (gcnt !== 11) begin miscompares++; $display("FAIL read_gnt_len_%0d: got %0d want 11", r, gcnt); end
      prev = e;
    end
  endtask

  task automatic test_write_vs_tick();
    bit found;
    wait_tick(100, found);
    vectors++;
    if (!found) begin miscompares++; $display("FAIL wt_tick: got none want tick"); end
    ifc.wr_req = 1'b1;
    step();
    ifc.wr_req = 1'b0;
    step();
    vectors++;
    if ({ifc.do_it_write, ifc.do_it_read, ifc.gnt} !== 5'b10_100) begin
      miscompares++;
      $display("FAIL wt_write_first: got %b want 10100", {ifc.do_it_write, ifc.do_it_read, ifc.gnt});
    end
  endtask

  task automatic test_bus_isolation();
    for (int i = 0; i < 8; i++) begin
      ifc.init_bus  = 4'($urandom);
      ifc.read_bus  = 4'($urandom);
      ifc.write_bus = 4'($urandom);
      ifc.read_done = (i == 3);
      #1;
      vectors++;
      if ({ifc.gnt, bus_o} !== {3'b100, ifc.write_bus}) begin
        miscompares++;
        $display("FAIL iso_%0d: got %b want %b", i, {ifc.gnt, bus_o}, {3'b100, ifc.write_bus});
      end
      step();
    end
    ifc.read_done  = 1'b0;
    ifc.write_done = 1'b1;
    step();
    ifc.write_done = 1'b0;
    ifc.init_bus   = 4'($urandom);
    ifc.read_bus   = 4'($urandom);
    ifc.write_bus  = 4'b0000;
    #1;
    vectors++;
    if ({ifc.gnt, bus_o} !== 7'b000_1111) begin
      miscompares++; $display("FAIL iso_idle: got %b want 0001111", {ifc.gnt, bus_o});
    end
    step();
    vectors++;
    if ({ifc.do_it_read, ifc.gnt} !== 4'b1_010) begin
      miscompares++; $display("FAIL wt_read_after: got %b want 1010", {ifc.do_it_read, ifc.gnt});
    end
    finish_read(10);
  endtask

  task automatic test_timeout();
    int e;
    bit found;
    wait_start(1, 120, found);
    e = cyc;
    vectors++;
    if (!found || !is_tick(e - 2)) begin
      miscompares++; $display("FAIL to_start: got found=%0d cycle=%0d want pulse 2 after tick", found, e);
    end
    for (int k = 0; k < TIMEOUT - 1; k++) step();
    vectors++;
    if ({ifc.gnt, ifc.timeout_err} !== 4'b010_0) begin
      miscompares++; $display("FAIL to_before: got %b want 0100", {ifc.gnt, ifc.timeout_err});
    end
    step();
    vectors++;
    if ({ifc.gnt, ifc.busy, ifc.timeout_err} !== 5'b000_0_1) begin
      miscompares++; $display("FAIL to_expire: got %b want 00001", {ifc.gnt, ifc.busy, ifc.timeout_err});
    end
    wait_start(1, 10, found);
    vectors++;
    if (!found || cyc !== e + 65 || ifc.read_overrun !== 1'b0) begin
      miscompares++;
      $display("FAIL to_next_read: got found=%0d cycle=%0d ovr=%b want cycle %0d ovr 0", found, cyc, ifc.read_overrun, e + 65);
    end
    finish_read(10);
  endtask

  task automatic test_overrun();
    int t;
    int rs;
    int nreads;
    bit found;
    wait_tick(100, found);
    t = cyc;
    nreads = 0;
    rs = -1;
    vectors++;
    if (!found) begin miscompares++; $display("FAIL ovr_tick: got none want tick"); end
    ifc.wr_req = 1'b1;
    step();
    ifc.wr_req = 1'b0;
    step();
    vectors++;
    if (ifc.do_it_write !== 1'b1) begin miscompares++; $display("FAIL ovr_write: got %b want 1", ifc.do_it_write); end
    while (cyc < t + 49) begin
      if (ifc.do_it_read) nreads++;
      step();
    end
    vectors++;
    if (ifc.read_overrun !== 1'b0) begin miscompares++; $display("FAIL ovr_early: got %b want 0", ifc.read_overrun); end
    step();
    step();
    vectors++;
    if ({ifc.read_overrun, ifc.gnt, 4'(nreads)} !== 8'b1_100_0000) begin
      miscompares++;
      $display("FAIL ovr_set: got ovr=%b gnt=%b reads=%0d want 1 100 0", ifc.read_overrun, ifc.gnt, nreads);
    end
    ifc.write_done = 1'b1;
    step();
    ifc.write_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (ifc.do_it_read) begin nreads++; rs = cyc; end
      ifc.read_done = (rs >= 0) && (cyc == rs + 10);
      step();
    end
    ifc.read_done = 1'b0;
    vectors++;
    if (nreads !== 1 || ifc.gnt !== 3'b000) begin
      miscompares++; $display("FAIL ovr_single_read: got reads=%0d gnt=%b want 1 000", nreads, ifc.gnt);
    end
  endtask

  task automatic test_reset_mid_write();
    bit found;
    ifc.wr_req = 1'b1;
    step();
    ifc.wr_req = 1'b0;
    step();
    ifc.write_bus = 4'b0110;
    #1;
    vectors++;
    if ({ifc.do_it_write, ifc.gnt, bus_o} !== 8'b1_100_0110) begin
      miscompares++; $display("FAIL mid_write: got %b want 11000110", {ifc.do_it_write, ifc.gnt, bus_o});
    end
    #1 reset = 1'b0;
    #1;
    vectors++;
    if ({ifc.do_it_inic, ifc.do_it_read, ifc.do_it_write, ifc.gnt, ifc.busy, bus_o} !== 11'b000_000_0_1111) begin
      miscompares++;
      $display("FAIL async_rst_ctrl: got %b want 00000001111",
               {ifc.do_it_inic, ifc.do_it_read, ifc.do_it_write, ifc.gnt, ifc.busy, bus_o});
    end
    vectors++;
    if ({ifc.init_ok, ifc.timeout_err, ifc.read_overrun} !== 3'b000) begin
      miscompares++;
      $display("FAIL async_rst_flags: got %b want 000", {ifc.init_ok, ifc.timeout_err, ifc.read_overrun});
    end
    for (int i = 0; i < 3; i++) step();
    #2 reset = 1'b1;
    step();
    vectors++;
    if ({ifc.do_it_inic, ifc.gnt, ifc.init_ok} !== 5'b1_001_0) begin
      miscompares++; $display("FAIL reinit_start: got %b want 10010", {ifc.do_it_inic, ifc.gnt, ifc.init_ok});
    end
    for (int k = 0; k < 5; k++) step();
    ifc.init_done = 1'b1;
    step();
    ifc.init_done = 1'b0;
    vectors++;
    if ({ifc.gnt, ifc.init_ok} !== 4'b000_1) begin
      miscompares++; $display("FAIL reinit_done: got %b want 0001", {ifc.gnt, ifc.init_ok});
    end
    wait_start(0, 5, found);
    vectors++;
    if (found) begin miscompares++; $display("FAIL reinit_repeat: got extra init pulse want none"); end
  endtask

  initial begin
    ifc.wr_req     = 1'b0;
    ifc.init_req   = 1'b0;
    ifc.init_done  = 1'b0;
    ifc.read_done  = 1'b0;
    ifc.write_done = 1'b0;
    ifc.init_bus   = 4'b0000;
    ifc.read_bus   = 4'b0000;
    ifc.write_bus  = 4'b0000;
    test_reset();
    test_init();
    test_periodic_read();
    test_write_vs_tick();
    test_bus_isolation();
    test_timeout();
    test_overrun();
    test_reset_mid_write();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL sim_timeout: got no completion want finish within 200000 time units");
    $fatal(1, "simulation time limit reached");
  end

endmodule
